sequenciador_pilha: RTL
=======================

Name: sequenciador_pilha

Overview:
Multi-cycle control unit for the stack-machine datapath. It fetches instruction words from the program ROM and decodes them. It then sequences the stack (push/pop, input select), the temp1/temp2 operand registers and the ALU, and handles jumps. It tracks stack depth internally, so overflow, underflow and illegal opcodes stop the machine in a sticky error state.

Parameters:
DATA_W, 8, datapath/operand width
ADDR_W, 5, ROM address width; PC wraps modulo 2^ADDR_W
STACK_DEPTH, 8, stack capacity in entries

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
rom_addr  out  ADDR_W  program counter, drives ROM address
rom_data  in  4+DATA_W  instruction word; [DATA_W+3:DATA_W]=opcode, [DATA_W-1:0]=operand; combinational ROM, valid same cycle
pilha_dout  in  DATA_W  stack top, combinational
pilha_push  out  1  push strobe, acts on next rising edge
pilha_pop  out  1  pop strobe
pilha_sel  out  1  stack input select: 0=din_uc, 1=ALU result
din_uc  out  DATA_W  immediate value for push
temp1_load  out  1  load temp1 from pilha_dout (operand A)
temp2_load  out  1  load temp2 from pilha_dout (operand B)
ula_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT
profundidade  out  $clog2(STACK_DEPTH+1)  current stack depth
estado_atual  out  4  state code, for debug
halted  out  1  HALT executed, sticky
erro  out  1  fault, sticky

Behaviour:
- Opcodes: 0 NOP, 1 PUSH imm, 2 POP, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 NOT, 8 JMP addr, 9 JZ addr, F HALT. Opcodes A–E are illegal.
- State codes: FETCH=0, DECODE=1, POP_A=2, EXEC=3, HALT=4, ERRO=5.
- Reset:
  - pc=0, ir=0, depth=0, state FETCH.
  - All strobes 0, ula_op=0, pilha_sel=0, din_uc=0, halted=0, erro=0.
  - Reset wins over everything, including mid-instruction.
- FETCH: ir<=rom_data; pc<=pc+1 (wraps); go to DECODE.
- DECODE, per opcode:
  - NOP: go to FETCH.
  - PUSH: if depth==STACK_DEPTH, go to ERRO. Else pilha_push=1, pilha_sel=0, din_uc=operand, depth+1, go to FETCH.
  - POP: if depth==0, go to ERRO. Else pilha_pop=1, depth-1, go to FETCH.
  - ADD/SUB/AND/OR: if depth<2, go to ERRO. Else temp2_load=1, pilha_pop=1, go to POP_A.
  - NOT: if depth<1, go to ERRO. Else temp1_load=1, pilha_pop=1, go to EXEC.
  - JMP: pc<=operand[ADDR_W-1:0]; go to FETCH.
  - JZ: if depth==0, go to ERRO. Else pilha_pop=1, depth-1; if pilha_dout==0 then pc<=operand[ADDR_W-1:0]; go to FETCH.
  - HALT: go to HALT.
  - Illegal opcode: go to ERRO.
- POP_A: temp1_load=1, pilha_pop=1; go to EXEC.
- EXEC: pilha_push=1, pilha_sel=1; go to FETCH.
  - Net depth change: binary op -1, NOT 0.
  - Result is temp1 op temp2, i.e. SUB = (second-from-top) - top.
- ula_op is driven from ir during POP_A and EXEC; it is 0 in all other states.
- pilha_push and pilha_pop are never high in the same cycle. Every strobe is high for exactly one cycle.
- Latency: NOP/PUSH/POP/JMP/JZ take 2 cycles, NOT takes 3, binary ops take 4.
- HALT and ERRO are absorbing states:
  - All strobes 0.
  - pc and depth frozen.
  - halted=1 in HALT; erro=1 in ERRO. Both stay high until reset.
- On a faulting DECODE no strobe is asserted and depth is unchanged.
- depth never exceeds STACK_DEPTH and never goes below 0.

Test Plan:
1. Program PUSH 5, PUSH 3, ADD, HALT -> din_uc=5 then 3 on push cycles; temp2_load then temp1_load; EXEC has ula_op=0, pilha_sel=1; profundidade=1; halted=1 from cycle 11 after reset release; rom_addr=4 stays frozen.
2. PUSH 9, PUSH 4, SUB -> temp2_load while pilha_dout=4; temp1_load while pilha_dout=9; ula_op=1 in POP_A and EXEC; profundidade=1.
3. PUSH 7, ADD -> erro=1 the cycle after the ADD DECODE; no pop in that DECODE; profundidade stays 1; state 5 held for 20+ cycles.
4. STACK_DEPTH+1 consecutive PUSH -> final PUSH raises erro; profundidade=STACK_DEPTH; pilha_push never asserted for it.
5. PUSH 0, JZ 6 -> pop strobe, rom_addr=6 at next FETCH. PUSH 1, JZ 6 -> no jump, pc sequential. JMP 31 then NOP -> rom_addr wraps 31->0.
6. Assert reset during POP_A of an ADD -> next cycle: estado_atual=0, rom_addr=0, profundidade=0, all strobes 0. Separately, opcode 0xA -> erro=1.

Source files
------------

// File: rtl/sequenciador_pilha.sv
// Multi-cycle control unit for the stack-machine datapath: fetch/decode, stack and
// operand-register sequencing, jumps, and sticky halt/fault states with depth tracking.
module sequenciador_pilha #(
  parameter  int DATA_W      = 8,
  parameter  int ADDR_W      = 5,
  parameter  int STACK_DEPTH = 8,
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W+3:0]   rom_data,
  input  logic [DATA_W-1:0]   pilha_dout,
  output logic                pilha_push,
  output logic                pilha_pop,
  output logic                pilha_sel,
  output logic [DATA_W-1:0]   din_uc,
  output logic                temp1_load,
  output logic                temp2_load,
  output logic [2:0]          ula_op,
  output logic [DEPTH_W-1:0]  profundidade,
  output logic [3:0]          estado_atual,
  output logic                halted,
  output logic                erro
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_POP_A  = 4'd2,
    S_EXEC   = 4'd3,
    S_HALT   = 4'd4,
    S_ERRO   = 4'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W+3:0]   ir_q, ir_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;

  logic [3:0]          opcode;
  logic [DATA_W-1:0]   operand;
  logic [2:0]          alu_sel;

  assign opcode  = ir_q[DATA_W+3:DATA_W];
  assign operand = ir_q[DATA_W-1:0];
  // ALU opcodes are contiguous from ADD, so the ALU select is a fixed offset
  assign alu_sel = 3'(opcode - OP_ADD);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    pilha_push = 1'b0;
    pilha_pop  = 1'b0;
    pilha_sel  = 1'b0;
    din_uc     = '0;
    temp1_load = 1'b0;
    temp2_load = 1'b0;
    ula_op     = 3'd0;

    case (state_q)
      S_FETCH: begin
        ir_d    = rom_data;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_NOP: ;
          OP_PUSH: begin
            if (depth_q == DEPTH_FULL) begin
              state_d = S_ERRO;
            end else begin
              pilha_push = 1'b1;
              din_uc     = operand;
            end
          end
          OP_POP: begin
            if (depth_q == '0) state_d = S_ERRO;
            else               pilha_pop = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            // Top of stack is operand B; the second entry becomes operand A in POP_A
            if (depth_q < DEPTH_W'(2)) begin
              state_d = S_ERRO;
            end else begin
              temp2_load = 1'b1;
              pilha_pop  = 1'b1;
              state_d    = S_POP_A;
            end
          end
          OP_NOT: begin
            if (depth_q == '0) begin
              state_d = S_ERRO;
            end else begin
              temp1_load = 1'b1;
              pilha_pop  = 1'b1;
              state_d    = S_EXEC;
            end
          end
          OP_JMP: pc_d = operand[ADDR_W-1:0];
          OP_JZ: begin
            if (depth_q == '0) begin
              state_d = S_ERRO;
            end else begin
              pilha_pop = 1'b1;
              if (pilha_dout == '0) pc_d = operand[ADDR_W-1:0];
            end
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_ERRO;
        endcase
      end
      S_POP_A: begin
        temp1_load = 1'b1;
        pilha_pop  = 1'b1;
        ula_op     = alu_sel;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        pilha_push = 1'b1;
        pilha_sel  = 1'b1;
        ula_op     = alu_sel;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERRO:  state_d = S_ERRO;
      default: state_d = S_ERRO;
    endcase
  end

  // Depth follows the stack strobes directly, so it always mirrors the real stack
  always_comb begin
    depth_d = depth_q;
    if (pilha_push)     depth_d = depth_q + DEPTH_W'(1);
    else if (pilha_pop) depth_d = depth_q - DEPTH_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      depth_q <= depth_d;
    end
  end

  assign rom_addr     = pc_q;
  assign profundidade = depth_q;
  assign estado_atual = state_q;
  assign halted       = (state_q == S_HALT);
  assign erro         = (state_q == S_ERRO);

endmodule
